// File: rtl/nx_fifo_ctrl_wm_pkg.sv
// Shared width helpers for the FIFO controller.
// Pointer and count widths are derived from DEPTH with these functions.
package nx_fifo_pkg;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nx_fifo_ctrl_wm_if.sv
// Request, threshold and status bundle of the FIFO controller.
// The slave modport is the controller side.
interface nx_fifo_ctrl_wm_if
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int AW = max(1, clog2(DEPTH));
  localparam int CW = clog2(DEPTH + 1);

  logic          wen;
  logic          ren;
  logic          clear;
  logic [CW-1:0] af_th;
  logic [CW-1:0] ae_th;
  logic          clr_err;
  logic          clr_hwm;

  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] used_slots;
  logic [CW-1:0] free_slots;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic          underflow;
  logic          overflow;
  logic          underflow_sticky;
  logic          overflow_sticky;
  logic [CW-1:0] hwm;

  modport master (
    output wen, ren, clear, af_th, ae_th, clr_err, clr_hwm,
    input  empty, full, almost_full, almost_empty, used_slots, free_slots,
           rptr, wptr, underflow, overflow, underflow_sticky, overflow_sticky, hwm
  );

  modport slave (
    input  wen, ren, clear, af_th, ae_th, clr_err, clr_hwm,
    output empty, full, almost_full, almost_empty, used_slots, free_slots,
           rptr, wptr, underflow, overflow, underflow_sticky, overflow_sticky, hwm
  );
endinterface

// File: rtl/nx_fifo_ctrl_wm_ptr_wrap.sv
// Storage address register: increments on request and wraps at DEPTH-1,
// so non-power-of-two depths never address past the array.
module nx_fifo_ptr_wrap #(
  parameter int AW    = 2,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/nx_fifo_ctrl_wm.sv
// FIFO occupancy controller with watermarks, sticky errors and high-water mark.
// Status is registered from the next-cycle occupancy; error pulses are combinational.
module nx_fifo_ctrl_wm
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  nx_fifo_ctrl_wm_if.slave bus
);
  localparam int AW = max(1, clog2(DEPTH));
  localparam int CW = clog2(DEPTH + 1);

  logic [CW-1:0] used_q, used_d;
  logic [CW-1:0] free_q, free_d;
  logic [CW-1:0] hwm_q, hwm_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovs_q, ovs_d;
  logic          uds_q, uds_d;
  logic          wr_ok, rd_ok;
  logic          ovf, udf;
  logic [AW-1:0] rptr, wptr;

  always_comb begin
    ovf   = bus.wen & full_q;
    udf   = bus.ren & empty_q;
    wr_ok = bus.wen & ~full_q & ~bus.clear;
    rd_ok = bus.ren & ~empty_q & ~bus.clear;

    used_d = bus.clear ? '0 : used_q + CW'(wr_ok) - CW'(rd_ok);
    free_d  = CW'(DEPTH) - used_d;
    empty_d = (used_d == '0);
    full_d  = (used_d == CW'(DEPTH));
    af_d    = (used_d >= bus.af_th);
    ae_d    = (used_d <= bus.ae_th);

    // a new error in the same cycle as clr_err must stay visible
    ovs_d = ovf | (ovs_q & ~bus.clr_err);
    uds_d = udf | (uds_q & ~bus.clr_err);

    hwm_d = hwm_q;
    if (bus.clear) begin
      hwm_d = '0;
    end else if (bus.clr_hwm) begin
      hwm_d = used_d;
    end else if (used_d > hwm_q) begin
      hwm_d = used_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      used_q  <= '0;
      free_q  <= CW'(DEPTH);
      hwm_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= (bus.af_th == '0);
      ae_q    <= 1'b1;
      ovs_q   <= 1'b0;
      uds_q   <= 1'b0;
    end else begin
      used_q  <= used_d;
      free_q  <= free_d;
      hwm_q   <= hwm_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovs_q   <= ovs_d;
      uds_q   <= uds_d;
    end
  end

  nx_fifo_ptr_wrap #(.AW(AW), .DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (rd_ok),
    .ptr   (rptr)
  );

  nx_fifo_ptr_wrap #(.AW(AW), .DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (wr_ok),
    .ptr   (wptr)
  );

  assign bus.used_slots       = used_q;
  assign bus.free_slots       = free_q;
  assign bus.hwm              = hwm_q;
  assign bus.empty            = empty_q;
  assign bus.full             = full_q;
  assign bus.almost_full      = af_q;
  assign bus.almost_empty     = ae_q;
  assign bus.overflow_sticky  = ovs_q;
  assign bus.underflow_sticky = uds_q;
  assign bus.rptr             = rptr;
  assign bus.wptr             = wptr;
  assign bus.overflow         = ovf;
  assign bus.underflow        = udf;
endmodule

// File: tb/tb_nx_fifo_ctrl_wm.sv
// Bench for nx_fifo_ctrl_wm: DEPTH=5 and DEPTH=4 instances driven in lockstep,
// each compared against its own reference model through a scoreboard queue.
module tb_nx_fifo_ctrl_wm;

  typedef struct {
    logic [31:0] used, free, rptr, wptr, empty, full, af, ae, ovs, uds, hwm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nx_fifo_ctrl_wm_if #(.DEPTH(5)) if5 ();
  nx_fifo_ctrl_wm_if #(.DEPTH(4)) if4 ();

  nx_fifo_ctrl_wm #(.DEPTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));
  nx_fifo_ctrl_wm #(.DEPTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  int   dep[2] = '{5, 4};
  int   m_used[2], m_rptr[2], m_wptr[2], m_ovs[2], m_uds[2], m_hwm[2];
  int   af_th = 3;
  int   ae_th = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sample(input int i, output exp_t o, output logic [31:0] ovf, output logic [31:0] udf);
    if (i == 0) begin
      o.used = 32'(if5.used_slots);  o.free = 32'(if5.free_slots);
      o.rptr = 32'(if5.rptr);        o.wptr = 32'(if5.wptr);
      o.empty = 32'(if5.empty);      o.full = 32'(if5.full);
      o.af = 32'(if5.almost_full);   o.ae = 32'(if5.almost_empty);
      o.ovs = 32'(if5.overflow_sticky); o.uds = 32'(if5.underflow_sticky);
      o.hwm = 32'(if5.hwm);
      ovf = 32'(if5.overflow);       udf = 32'(if5.underflow);
    end else begin
      o.used = 32'(if4.used_slots);  o.free = 32'(if4.free_slots);
      o.rptr = 32'(if4.rptr);        o.wptr = 32'(if4.wptr);
      o.empty = 32'(if4.empty);      o.full = 32'(if4.full);
      o.af = 32'(if4.almost_full);   o.ae = 32'(if4.almost_empty);
      o.ovs = 32'(if4.overflow_sticky); o.uds = 32'(if4.underflow_sticky);
      o.hwm = 32'(if4.hwm);
      ovf = 32'(if4.overflow);       udf = 32'(if4.underflow);
    end
  endtask

  task automatic predict(input int i, input bit w, input bit r, input bit c,
                         input bit ce, input bit ch, input bit rs);
    exp_t e;
    bit   is_full, is_empty, ovf, udf, wok, rok;
    int   un;
    is_full  = (m_used[i] == dep[i]);
    is_empty = (m_used[i] == 0);
    ovf = w && is_full;
    udf = r && is_empty;
    wok = w && !is_full && !c;
    rok = r && !is_empty && !c;
    if (rs) begin
      m_used[i] = 0; m_rptr[i] = 0; m_wptr[i] = 0;
      m_ovs[i] = 0;  m_uds[i] = 0;  m_hwm[i] = 0;
    end else begin
      un = c ? 0 : m_used[i] + int'(wok) - int'(rok);
      if (c) begin
        m_rptr[i] = 0; m_wptr[i] = 0;
      end else begin
        if (rok) m_rptr[i] = (m_rptr[i] == dep[i] - 1) ? 0 : m_rptr[i] + 1;
        if (wok) m_wptr[i] = (m_wptr[i] == dep[i] - 1) ? 0 : m_wptr[i] + 1;
      end
      m_ovs[i] = int'(ovf || (m_ovs[i] != 0 && !ce));
      m_uds[i] = int'(udf || (m_uds[i] != 0 && !ce));
      if (c) m_hwm[i] = 0;
      else if (ch) m_hwm[i] = un;
      else if (un > m_hwm[i]) m_hwm[i] = un;
      m_used[i] = un;
    end
    e.used  = m_used[i];
    e.free  = dep[i] - m_used[i];
    e.rptr  = m_rptr[i];
    e.wptr  = m_wptr[i];
    e.empty = 32'(m_used[i] == 0);
    e.full  = 32'(m_used[i] == dep[i]);
    e.af    = 32'(m_used[i] >= af_th);
    e.ae    = 32'(m_used[i] <= ae_th);
    e.ovs   = m_ovs[i];
    e.uds   = m_uds[i];
    e.hwm   = m_hwm[i];
    sb_q.push_back(e);
  endtask

  task automatic step(input bit w, input bit r, input bit c,
                      input bit ce, input bit ch, input bit rs);
    exp_t        o, e;
    logic [31:0] ovf, udf;
    string       p;
    rst_n = !rs;
    if5.wen = w; if5.ren = r; if5.clear = c; if5.clr_err = ce; if5.clr_hwm = ch;
    if4.wen = w; if4.ren = r; if4.clear = c; if4.clr_err = ce; if4.clr_hwm = ch;
    if5.af_th = 3'(af_th); if5.ae_th = 3'(ae_th);
    if4.af_th = 3'(af_th); if4.ae_th = 3'(ae_th);
    #1;
    for (int i = 0; i < 2; i++) begin
      p = $sformatf("d%0d", dep[i]);
      sample(i, o, ovf, udf);
      chk({p, ".overflow"},  ovf, 32'(w && m_used[i] == dep[i]));
      chk({p, ".underflow"}, udf, 32'(r && m_used[i] == 0));
      predict(i, w, r, c, ce, ch, rs);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      p = $sformatf("d%0d", dep[i]);
      e = sb_q.pop_front();
      sample(i, o, ovf, udf);
      chk({p, ".used"},  o.used,  e.used);
      chk({p, ".free"},  o.free,  e.free);
      chk({p, ".rptr"},  o.rptr,  e.rptr);
      chk({p, ".wptr"},  o.wptr,  e.wptr);
      chk({p, ".empty"}, o.empty, e.empty);
      chk({p, ".full"},  o.full,  e.full);
      chk({p, ".afull"}, o.af,    e.af);
      chk({p, ".aempty"}, o.ae,   e.ae);
      chk({p, ".ovf_sticky"}, o.ovs, e.ovs);
      chk({p, ".udf_sticky"}, o.uds, e.uds);
      chk({p, ".hwm"},   o.hwm,   e.hwm);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_used[i] = 0; m_rptr[i] = 0; m_wptr[i] = 0;
      m_ovs[i] = 0;  m_uds[i] = 0;  m_hwm[i] = 0;
    end
    // reset, thresholds af=3 ae=1
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // fill: DEPTH=5 reaches full, DEPTH=4 overflows on the fifth write
    repeat (5) step(1, 0, 0, 0, 0, 0);
    // full with wen&ren: write rejected, read accepted
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    // drain past empty, then one underflowing read
    repeat (5) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    // empty with wen&ren: read rejected, write accepted; then clear stickies
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    // build to 3, non-boundary wen&ren, reload hwm, clear with a write pending
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    // af_th=0 forces almost_full
    af_th = 0;
    step(0, 0, 0, 0, 0, 0);
    af_th = 3;
    // mid-operation reset with a write request
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 1);
    // random traffic with occasional threshold changes, clears and resets
    for (int k = 0; k < 80; k++) begin
      af_th = int'($urandom_range(0, 6));
      ae_th = int'($urandom_range(0, 6));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0));
    end
    if (sb_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
